sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory-side responder for the CPU MEM-stage data port.
- Accepts word-aligned read/write requests (address, lane-replicated write data, byte enables, read/write strobes) and runs timed cycles on an external asynchronous 32-bit SRAM.
- Returns the full read word to the MEM stage; the MEM stage performs lane extraction and sign extension.
- Holds `stall` high so the pipeline freezes while an access is in flight.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- RD_CYCLES, 2, read-strobe length in clk cycles (legal 1..15).
- WR_CYCLES, 2, write-pulse (we_n low) length in clk cycles (legal 1..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_access_addr  in  32  byte address from MEM stage.
- mem_access_data_out  in  32  write data, already lane-replicated.
- mem_byte_en  in  4  active-high byte lanes for writes; bit i covers data[8i+7:8i].
- mem_access_read  in  1  read request, held by pipeline while stall=1.
- mem_access_write  in  1  write request, held by pipeline while stall=1.
- mem_access_data_in  out  32  registered read word to MEM stage.
- stall  out  1  freeze pipeline; access not yet complete.
- sram_addr  out  ADDR_W  = latched mem_access_addr[ADDR_W+1:2].
- sram_dq_o  out  32  write data to pad.
- sram_dq_i  in  32  read data from pad.
- sram_dq_oe  out  1  pad output enable.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_be_n  out  4  byte enables, active-low.

Behaviour:
- Reset state, effective on the cycle rst=1:
  - state=IDLE, counter=0, mem_access_data_in=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - stall forced 0 while rst=1.
- Reset mid-access aborts immediately: pad strobes return high on the same edge, and no data capture occurs.
- stall (combinational) = (read|write) & (state!=DONE) & ~rst. It is high in the request cycle itself.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE transitions:
  - write=1 (including write&read, where write wins and read is ignored) -> WR_SETUP.
  - read=1 only -> RD.
  - On entering either branch, latch address, data and be (write only).
- RD:
  - ce_n=0, oe_n=0, be_n=0, dq_oe=0.
  - Stays RD_CYCLES cycles.
  - On the final RD edge, capture sram_dq_i into mem_access_data_in, then go to DONE.
- WR_SETUP (1 cycle):
  - ce_n=0, dq_oe=1, addr/data/be_n=~be driven, we_n=1.
  - Then go to WR_PULSE.
- WR_PULSE (WR_CYCLES cycles): we_n=0, all else held. Then go to WR_HOLD.
- WR_HOLD (1 cycle): we_n=1, data and dq_oe still driven. Then go to DONE.
- DONE (1 cycle):
  - stall=0 and the pipeline advances.
  - All strobes high, dq_oe=0.
  - Next state is IDLE.
  - A request present in the following cycle is a new access.
- Latency:
  - Read: stall high RD_CYCLES+1 cycles; data valid from DONE onward.
  - Write: stall high WR_CYCLES+3 cycles.
- Data retention: mem_access_data_in holds its value until the next read completes. Writes never change it.
- Request changes after the IDLE latch are ignored until DONE.
- Addresses:
  - addr[1:0] are ignored; lane selection comes only from mem_byte_en.
  - Upper address bits above ADDR_W+1 are ignored (alias).
- Write with mem_byte_en=0: full cycle runs with be_n=4'hF, so memory is unchanged but timing is identical.
- Counter: 4-bit down-counter loaded with N-1 on state entry; the state exits when the counter is 0.
- All sram_* outputs are registered; there are no combinational pad paths.

Decomposition:
- defs.v gets the `SRAM_STATE_IDLE/RD/WR_SETUP/WR_PULSE/WR_HOLD/DONE` encodings (3-bit) and the `SRAM_ADDR_W` default.
- Reuses the existing MEM_ACCESS constants; no new ones.
- Single module with the counter inline; no sub-module.

Test Plan:
- Read, RD_CYCLES=2, addr=0x0000_0104, SRAM model returns 0xDEADBEEF -> sram_addr=0x41, oe_n low 2 cycles, stall high 3 cycles, mem_access_data_in=0xDEADBEEF from cycle 3.
- Byte write, addr=0x0000_0103, data=0xA5A5A5A5, be=4'b1000, WR_CYCLES=2 -> sram_be_n=4'b0111; we_n low exactly 2 cycles, bracketed by 1 setup and 1 hold cycle with dq_oe=1; stall high 5 cycles; model word lane3=0xA5, other lanes unchanged.
- Back-to-back read then write, with request lines changing in the DONE cycle -> second access starts in the cycle after DONE; mem_access_data_in retains the read value through the write.
- read=1 and write=1 together -> write cycle only, oe_n never low, mem_access_data_in unchanged.
- rst=1 during WR_PULSE -> next edge: we_n=1, ce_n=1, dq_oe=0, state IDLE, stall=0 while rst is high.
- RD_CYCLES=1, WR_CYCLES=15 corner -> stall lengths are 2 and 18 cycles respectively.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the MEM-stage SRAM responder.
//   - SRAM_ADDR_W      : default SRAM word-address width
//   - sram_state_e     : 3-bit FSM state encodings
//   - sram_strobe_t    : bundle of the single-bit pad controls
//   - SRAM_STROBE_IDLE : pad controls with the SRAM deselected and bus released
//   - cycles_to_load   : converts a strobe length in cycles to a counter load
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 20;

    typedef enum logic [2:0] {
        SRAM_STATE_IDLE     = 3'd0,
        SRAM_STATE_RD       = 3'd1,
        SRAM_STATE_WR_SETUP = 3'd2,
        SRAM_STATE_WR_PULSE = 3'd3,
        SRAM_STATE_WR_HOLD  = 3'd4,
        SRAM_STATE_DONE     = 3'd5
    } sram_state_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } sram_strobe_t;

    localparam sram_strobe_t SRAM_STROBE_IDLE = '{
        ce_n:  1'b1,
        oe_n:  1'b1,
        we_n:  1'b1,
        dq_oe: 1'b0
    };

    // A state that lasts N cycles loads N-1 and leaves when the count hits 0.
    function automatic logic [3:0] cycles_to_load(input int unsigned cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Responder for the CPU MEM-stage data port.  Turns a word-aligned
//   read/write request into a timed cycle on an external asynchronous 32-bit
//   SRAM and holds the pipeline in stall until the access is complete.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | no access; a request is latched on the next edge
//   RD          | ce_n/oe_n low for RD_CYCLES; data captured on last edge
//   WR_SETUP    | address/data/byte enables driven, we_n still high
//   WR_PULSE    | we_n low for WR_CYCLES
//   WR_HOLD     | we_n high again, data still driven
//   DONE        | stall released for one cycle, pads idle
//
// Ports
//   clk                  system clock, rising edge
//   rst                  synchronous active-high reset
//   mem_access_addr      byte address (bits [1:0] and above ADDR_W+1 ignored)
//   mem_access_data_out  lane-replicated write data
//   mem_byte_en          active-high write byte lanes
//   mem_access_read      read request, held while stall=1
//   mem_access_write     write request, held while stall=1 (wins over read)
//   mem_access_data_in   registered read word, kept until the next read
//   stall                combinational pipeline freeze
//   sram_addr            word address to the SRAM
//   sram_dq_o/_i/_oe     data pad output / input / output enable
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes
//   sram_be_n            active-low SRAM byte enables
// -----------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_access_addr,
    input  logic [31:0]       mem_access_data_out,
    input  logic [3:0]        mem_byte_en,
    input  logic              mem_access_read,
    input  logic              mem_access_write,
    output logic [31:0]       mem_access_data_in,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [3:0] RD_LOAD = cycles_to_load(RD_CYCLES);
    localparam logic [3:0] WR_LOAD = cycles_to_load(WR_CYCLES);

    sram_state_e  state;
    sram_state_e  state_nxt;
    logic [3:0]   count;
    logic [3:0]   count_nxt;
    logic         count_tc;
    logic         start;
    sram_strobe_t strobe_nxt;
    logic [3:0]   be_n_nxt;

    // Address bits outside the SRAM word range are don't-cares.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_access_addr[31:ADDR_W+2], mem_access_addr[1:0]};

    assign count_tc = (count == 4'd0);
    assign start    = (state == SRAM_STATE_IDLE) && (state_nxt != SRAM_STATE_IDLE);

    assign stall = (mem_access_read | mem_access_write) & (state != SRAM_STATE_DONE) & ~rst;

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SRAM_STATE_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            SRAM_STATE_IDLE: begin
                if (mem_access_write) begin
                    state_nxt = SRAM_STATE_WR_SETUP;
                end else if (mem_access_read) begin
                    state_nxt = SRAM_STATE_RD;
                end
            end
            SRAM_STATE_RD: begin
                if (count_tc) begin
                    state_nxt = SRAM_STATE_DONE;
                end
            end
            SRAM_STATE_WR_SETUP: state_nxt = SRAM_STATE_WR_PULSE;
            SRAM_STATE_WR_PULSE: begin
                if (count_tc) begin
                    state_nxt = SRAM_STATE_WR_HOLD;
                end
            end
            SRAM_STATE_WR_HOLD:  state_nxt = SRAM_STATE_DONE;
            SRAM_STATE_DONE:     state_nxt = SRAM_STATE_IDLE;
            default:             state_nxt = SRAM_STATE_IDLE;
        endcase

        // Load on entry to a timed state, otherwise count down to zero.
        count_nxt = 4'd0;
        if ((state_nxt == SRAM_STATE_RD) && (state != SRAM_STATE_RD)) begin
            count_nxt = RD_LOAD;
        end else if ((state_nxt == SRAM_STATE_WR_PULSE) && (state != SRAM_STATE_WR_PULSE)) begin
            count_nxt = WR_LOAD;
        end else if (!count_tc) begin
            count_nxt = count - 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: pad values for the cycle being entered.  Computing them
    // from state_nxt lets the pads be registered without a cycle of lag.
    // -------------------------------------------------------------------------
    always_comb begin
        strobe_nxt = SRAM_STROBE_IDLE;
        be_n_nxt   = 4'hF;
        case (state_nxt)
            SRAM_STATE_RD: begin
                strobe_nxt.ce_n = 1'b0;
                strobe_nxt.oe_n = 1'b0;
                be_n_nxt        = 4'h0;
            end
            SRAM_STATE_WR_SETUP: begin
                // Only reachable from IDLE, so the request lanes are current.
                strobe_nxt.ce_n  = 1'b0;
                strobe_nxt.dq_oe = 1'b1;
                be_n_nxt         = ~mem_byte_en;
            end
            SRAM_STATE_WR_PULSE: begin
                strobe_nxt.ce_n  = 1'b0;
                strobe_nxt.we_n  = 1'b0;
                strobe_nxt.dq_oe = 1'b1;
                be_n_nxt         = sram_be_n;
            end
            SRAM_STATE_WR_HOLD: begin
                strobe_nxt.ce_n  = 1'b0;
                strobe_nxt.dq_oe = 1'b1;
                be_n_nxt         = sram_be_n;
            end
            default: begin
                strobe_nxt = SRAM_STROBE_IDLE;
                be_n_nxt   = 4'hF;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pad registers and request latches.  sram_addr, sram_dq_o and sram_be_n
    // double as the request latches, so later request changes have no effect.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_be_n  <= 4'hF;
            sram_addr  <= '0;
            sram_dq_o  <= 32'd0;
        end else begin
            sram_ce_n  <= strobe_nxt.ce_n;
            sram_oe_n  <= strobe_nxt.oe_n;
            sram_we_n  <= strobe_nxt.we_n;
            sram_dq_oe <= strobe_nxt.dq_oe;
            sram_be_n  <= be_n_nxt;
            if (start) begin
                sram_addr <= mem_access_addr[ADDR_W+1:2];
            end
            if (start && (state_nxt == SRAM_STATE_WR_SETUP)) begin
                sram_dq_o <= mem_access_data_out;
            end
        end
    end

    // Read data is taken on the last RD edge, while oe_n is still low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_access_data_in <= 32'd0;
        end else if ((state == SRAM_STATE_RD) && count_tc) begin
            mem_access_data_in <= sram_dq_i;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_access_data_out;
    logic [3:0]  mem_byte_en;
    logic        mem_access_read;
    logic        mem_access_write;
    logic [31:0] mem_access_data_in;
    logic        stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_o;
    logic [31:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    sram_ctrl #(.ADDR_W(20), .RD_CYCLES(2), .WR_CYCLES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_access_addr     (mem_access_addr),
        .mem_access_data_out (mem_access_data_out),
        .mem_byte_en         (mem_byte_en),
        .mem_access_read     (mem_access_read),
        .mem_access_write    (mem_access_write),
        .mem_access_data_in  (mem_access_data_in),
        .stall               (stall),
        .sram_addr           (sram_addr),
        .sram_dq_o           (sram_dq_o),
        .sram_dq_i           (sram_dq_i),
        .sram_dq_oe          (sram_dq_oe),
        .sram_ce_n           (sram_ce_n),
        .sram_oe_n           (sram_oe_n),
        .sram_we_n           (sram_we_n),
        .sram_be_n           (sram_be_n)
    );

    // Corner-timing instance: RD_CYCLES=1, WR_CYCLES=15.
    logic        read_c, write_c, stall_c;
    logic [31:0] data_in_c, dq_o_c, dq_i_c;
    logic [19:0] addr_c;
    logic        dq_oe_c, ce_n_c, oe_n_c, we_n_c;
    logic [3:0]  be_n_c;
    assign dq_i_c = 32'h0BAD_F00D;

    sram_ctrl #(.ADDR_W(20), .RD_CYCLES(1), .WR_CYCLES(15)) dut_c (
        .clk                 (clk),
        .rst                 (rst),
        .mem_access_addr     (32'h0000_0010),
        .mem_access_data_out (32'h1111_2222),
        .mem_byte_en         (4'hF),
        .mem_access_read     (read_c),
        .mem_access_write    (write_c),
        .mem_access_data_in  (data_in_c),
        .stall               (stall_c),
        .sram_addr           (addr_c),
        .sram_dq_o           (dq_o_c),
        .sram_dq_i           (dq_i_c),
        .sram_dq_oe          (dq_oe_c),
        .sram_ce_n           (ce_n_c),
        .sram_oe_n           (oe_n_c),
        .sram_we_n           (we_n_c),
        .sram_be_n           (be_n_c)
    );

    // ---------------- SRAM model (256 words) ----------------
    logic [31:0] mem [0:255];

    function automatic logic [31:0] init_word(input int i);
        if (i == 8'h41) return 32'hDEAD_BEEF;
        if (i == 8'h40) return 32'h1122_3344;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
        end
    end

    assign sram_dq_i = mem[sram_addr[7:0]];

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on the main instance.  Called at a negedge; returns in the
    // DONE cycle with the request lines dropped.  Pops one expected read word.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output int n, output int oe_lo, output int we_lo, output int waits,
                          output logic [7:0] we_hist, output logic [19:0] addr_seen,
                          output logic [3:0] be_seen);
        mem_access_read     = r;
        mem_access_write    = w;
        mem_access_addr     = a;
        mem_access_data_out = d;
        mem_byte_en         = be;
        n = 0; oe_lo = 0; we_lo = 0; waits = 0;
        we_hist = 8'h00; addr_seen = '0; be_seen = 4'hF;
        #1;
        while (!stall && waits < 4) begin
            @(negedge clk);
            #1;
            waits++;
        end
        while (stall && n < 64) begin
            n++;
            @(negedge clk);
            // Requests are held but other fields are scrambled to show they
            // are not re-sampled after the latch.
            mem_access_addr     = $urandom;
            mem_access_data_out = $urandom;
            mem_byte_en         = 4'($urandom);
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) begin
                we_lo++;
                be_seen = sram_be_n;
            end
            if (sram_dq_oe) we_hist = {we_hist[6:0], sram_we_n};
            if (!sram_ce_n) addr_seen = sram_addr;
            #1;
        end
        mem_access_read  = 1'b0;
        mem_access_write = 1'b0;
        chk("data_in", mem_access_data_in, exp_q.pop_front());
    endtask

    task automatic access_c(input logic r, input logic w, output int n, output int we_lo);
        read_c  = r;
        write_c = w;
        n = 0; we_lo = 0;
        #1;
        while (stall_c && n < 64) begin
            n++;
            @(negedge clk);
            if (!we_n_c) we_lo++;
            #1;
        end
        read_c  = 1'b0;
        write_c = 1'b0;
    endtask

    int n, oe_lo, we_lo, waits;
    logic [7:0]  we_hist;
    logic [19:0] addr_seen;
    logic [3:0]  be_seen;

    initial begin
        rst = 1'b1;
        mem_access_read = 1'b1;
        mem_access_write = 1'b0;
        mem_access_addr = 32'h0;
        mem_access_data_out = 32'h0;
        mem_byte_en = 4'h0;
        read_c = 1'b0;
        write_c = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("stall_in_rst", 32'(stall), 32'd0);
        chk("rst_ce_n",  32'(sram_ce_n), 32'd1);
        chk("rst_oe_n",  32'(sram_oe_n), 32'd1);
        chk("rst_we_n",  32'(sram_we_n), 32'd1);
        chk("rst_be_n",  32'(sram_be_n), 32'hF);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr",  32'(sram_addr), 32'd0);
        chk("rst_dq_o",  sram_dq_o, 32'd0);
        chk("rst_data",  mem_access_data_in, 32'd0);
        mem_access_read = 1'b0;
        rst = 1'b0;

        // ---- read 0x104 ----
        @(negedge clk);
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("rd_stall", 32'(n), 32'd3);
        chk("rd_oe_lo", 32'(oe_lo), 32'd2);
        chk("rd_addr", 32'(addr_seen), 32'h41);
        chk("rd_we_lo", 32'(we_lo), 32'd0);

        // ---- byte write lane 3 ----
        @(negedge clk);
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h0000_0103, 32'hA5A5_A5A5, 4'b1000, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("wr_stall", 32'(n), 32'd5);
        chk("wr_we_lo", 32'(we_lo), 32'd2);
        chk("wr_we_hist", 32'(we_hist), 32'h09);
        chk("wr_be_n", 32'(be_seen), 32'(4'b0111));
        chk("wr_addr", 32'(addr_seen), 32'h40);
        chk("wr_oe_lo", 32'(oe_lo), 32'd0);
        chk("wr_mem40", mem[8'h40], 32'hA522_3344);

        // ---- back-to-back read then write ----
        @(negedge clk);
        exp_q.push_back(32'hA522_3344);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("b2b_rd_stall", 32'(n), 32'd3);
        exp_q.push_back(32'hA522_3344);
        access(1'b0, 1'b1, 32'h0000_0110, 32'h1234_5678, 4'hF, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("b2b_wait", 32'(waits), 32'd1);
        chk("b2b_wr_stall", 32'(n), 32'd5);
        chk("b2b_mem44", mem[8'h44], 32'h1234_5678);

        // ---- read and write together: write wins ----
        @(negedge clk);
        exp_q.push_back(32'hA522_3344);
        access(1'b1, 1'b1, 32'h0000_0120, 32'hCAFE_F00D, 4'b0011, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("rw_oe_lo", 32'(oe_lo), 32'd0);
        chk("rw_stall", 32'(n), 32'd5);
        chk("rw_mem48", mem[8'h48], merge(init_word(8'h48), 32'hCAFE_F00D, 4'b0011));

        // ---- write with no byte lanes ----
        @(negedge clk);
        exp_q.push_back(32'hA522_3344);
        access(1'b0, 1'b1, 32'h0000_012C, 32'hFFFF_FFFF, 4'h0, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("be0_stall", 32'(n), 32'd5);
        chk("be0_we_lo", 32'(we_lo), 32'd2);
        chk("be0_be_n", 32'(be_seen), 32'hF);
        chk("be0_mem4b", mem[8'h4B], init_word(8'h4B));

        // ---- aliased address, low bits set ----
        @(negedge clk);
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'hFFC0_0107, 32'h0, 4'h0, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("alias_addr", 32'(addr_seen), 32'h41);
        chk("alias_stall", 32'(n), 32'd3);

        // ---- reset during WR_PULSE ----
        @(negedge clk);
        mem_access_write = 1'b1;
        mem_access_addr = 32'h0000_0130;
        mem_access_data_out = 32'h5555_AAAA;
        mem_byte_en = 4'hF;
        waits = 0;
        while (sram_we_n && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        chk("reached_pulse", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_mid_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_mid_stall2", 32'(stall), 32'd0);
        mem_access_write = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ce_n", 32'(sram_ce_n), 32'd1);
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, n, oe_lo, we_lo, waits, we_hist, addr_seen, be_seen);
        chk("post_rst_rd_stall", 32'(n), 32'd3);

        // ---- corner timing instance ----
        @(negedge clk);
        access_c(1'b1, 1'b0, n, we_lo);
        chk("c_rd_stall", 32'(n), 32'd2);
        chk("c_rd_data", data_in_c, 32'h0BAD_F00D);
        @(negedge clk);
        access_c(1'b0, 1'b1, n, we_lo);
        chk("c_wr_stall", 32'(n), 32'd18);
        chk("c_wr_we_lo", 32'(we_lo), 32'd15);
        chk("c_data_kept", data_in_c, 32'h0BAD_F00D);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
